utc_timekeeper: RTL and testbench
=================================

# utc_timekeeper

Downstream consumer of the Thunderbolt TSIP receiver. Loads the UTC time fields that receiver decodes from each 8F-AB packet and keeps a running time-of-day, advanced by the GPS 1PPS edge. It publishes an atomic, always-consistent calendar time to the pulse generators and the register map, and flags disagreement between its own count and the GPS report.

## Interface
- CLKS_PER_SEC, 10_000_000: i_clk cycles per nominal second.
- PPS_TIMEOUT, 15_000_000: cycles without a PPS edge before the PPS is declared lost.
- i_clk  in  1  system clock, 10 MHz
- i_rst  in  1  synchronous, active-high reset
- i_pps  in  1  raw 1PPS from Thunderbolt, asynchronous
- i_thunder_packet_dv  in  1  one-cycle strobe: time fields below are valid
- i_year_h, i_year_l  in  8 each  binary year, {h,l}
- i_month, i_day, i_hour, i_minutes, i_seconds  in  8 each  binary fields (month 1-12, day 1-31)
- o_year  out  16  current year
- o_month, o_day, o_hour, o_minutes, o_seconds  out  8 each  current time
- o_time_valid  out  1  time loaded and PPS healthy
- o_tick  out  1  one-cycle pulse when the outputs have just advanced
- o_sync_err  out  1  one-cycle pulse: packet disagreed with the running count
- o_holdover  out  1  flywheel is running without PPS (only with the macro)

## Operation
- PPS path: 2-flop synchronizer, then a rising-edge detect. It produces a one-cycle pps_evt.
- Working registers wk_* hold the calendar. The outputs copy wk_* only in DONE, so updates are atomic.
- Packet semantics: the packet labels the most recent PPS. On dv, if o_time_valid is set and the packet differs from o_* in any field, pulse o_sync_err. In all cases load wk_* and o_* from the packet and set o_time_valid.
- Pending flags: pps_pend and pkt_pend are set by their events and cleared when serviced. Packet fields are captured into shadow regs at dv.
- FSM states: IDLE, LOAD, INC_SEC, INC_MIN, INC_HOUR, INC_DAY, INC_MON, INC_YEAR, DONE.
- IDLE: if pkt_pend, go to LOAD; else if pps_pend, go to INC_SEC.
- LOAD: copy shadow to wk_* and o_* (no o_tick), then return to IDLE.
- INC_x: increment the field. On overflow, reset it to its minimum and go to the next stage; otherwise go to DONE.
- Field rules:
  - Seconds wrap after 59. A loaded 60 (leap second) wraps to 0 with carry.
  - Minutes wrap after 59; hours wrap after 23.
  - Day wraps to 1 after days_in_month(wk_month, leap).
  - Month wraps to 1 after 12. Year increments mod 2^16.
- Leap year: year[1:0]==0. Valid for 1901-2099 only.
- Same-cycle pps_evt and dv: both pend. LOAD runs first, then the increment, because the new edge is newer than the packet's label.
- PPS loss: a counter clears on pps_evt and saturates at PPS_TIMEOUT. On reaching it, clear o_time_valid (macro off).
- Reset mid-operation: FSM to IDLE, pends cleared, outputs to reset values, wk_* discarded.

## Timing
- Reset values:
  - o_year=0, o_month=1, o_day=1, o_hour=0, o_minutes=0, o_seconds=0.
  - o_time_valid=0, o_tick=0, o_sync_err=0, o_holdover=0.
- i_pps edge to pps_evt: 3 cycles.
- pps_evt to o_tick: 1 cycle into pend, 1 cycle in IDLE, k INC stages (k=1..6), then DONE. o_tick is asserted in DONE, with o_* valid that same cycle.
- Worst case (year carry): 9 cycles. Always far below 1 s, so at most one increment is ever pending.
- dv to o_* loaded: 3 cycles (pend, IDLE, LOAD). o_sync_err is asserted in the cycle after dv.
- Increments while o_time_valid=0 still run if the time was ever loaded; they do not run before the first load.

## Configuration
- TOD_FLYWHEEL_EN defined:
  - On PPS timeout, inject an internal pps_evt, set o_holdover, and keep o_time_valid.
  - Thereafter inject every CLKS_PER_SEC cycles.
  - The first real pps_evt clears o_holdover and restarts the timer.
- TOD_FLYWHEEL_EN undefined: on timeout, clear o_time_valid; o_holdover is tied 0. The next packet re-validates.

## Structure
- Package utc_pkg:
  - FSM state encoding.
  - Field limits: SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, MONTH_MAX=12.
  - Days-per-month constants.
- Sub-module days_in_month: combinational. Inputs are month[7:0] and leap; output is a 5-bit day count (28/29/30/31). Out-of-range month returns 31.

## Test plan
- Load 2023-12-31 23:59:59, then a PPS edge: o_tick after the 6-stage cascade; outputs 2024-01-01 00:00:00.
- Leap-year day rollover:
  - Load 2024-02-28 23:59:59 + PPS: 2024-02-29 00:00:00.
  - Load 2023-02-28 23:59:59 + PPS: 2023-03-01 00:00:00.
- Running at 12:00:05: packet says 12:00:07. o_sync_err pulses once and o_seconds=7. A matching packet produces no o_sync_err.
- dv and pps_evt in the same cycle from 10:00:00: final 10:00:01 and exactly one o_tick.
- PPS removed for PPS_TIMEOUT:
  - Macro off: o_time_valid falls.
  - Macro on: o_holdover=1, and seconds advance every CLKS_PER_SEC cycles.
- Assert i_rst during INC_DAY: all outputs return to reset values and no o_tick occurs.

Source files
------------

// File: rtl/utc_pkg.sv
// Shared types and constants for the UTC timekeeper: FSM encoding, field limits,
// days-per-month table and the packed calendar record.
package utc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_INC_SEC,
    ST_INC_MIN,
    ST_INC_HOUR,
    ST_INC_DAY,
    ST_INC_MON,
    ST_INC_YEAR,
    ST_DONE
  } tk_state_t;

  localparam logic [7:0] SEC_MAX   = 8'd59;
  localparam logic [7:0] MIN_MAX   = 8'd59;
  localparam logic [7:0] HOUR_MAX  = 8'd23;
  localparam logic [7:0] MONTH_MAX = 8'd12;

  // Indexed directly by month[3:0]; slots 0 and 13-15 are out of range and read 31.
  localparam logic [4:0] DIM_TABLE [16] = '{
    5'd31, 5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31,
    5'd31, 5'd30, 5'd31, 5'd30, 5'd31, 5'd31, 5'd31, 5'd31
  };

  typedef struct packed {
    logic [15:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  minutes;
    logic [7:0]  seconds;
  } utc_time_t;

  localparam utc_time_t TIME_RESET = '{
    year: 16'd0, month: 8'd1, day: 8'd1, hour: 8'd0, minutes: 8'd0, seconds: 8'd0
  };

endpackage

// File: rtl/utc_timekeeper_days_in_month.sv
// Combinational month length lookup; out-of-range months report 31 days.
module days_in_month
  import utc_pkg::*;
(
  input  logic [7:0] month,
  input  logic       leap,
  output logic [4:0] days
);

  always_comb begin
    days = 5'd31;
    if (month[7:4] == 4'd0) days = DIM_TABLE[month[3:0]];
    if ((month == 8'd2) && leap) days = 5'd29;
  end

endmodule

// File: rtl/utc_timekeeper.sv
// Time-of-day keeper loaded from TSIP 8F-AB packets and advanced by 1PPS.
// Optional macro TOD_FLYWHEEL_EN: free-run on CLKS_PER_SEC when PPS is lost.
module utc_timekeeper
  import utc_pkg::*;
#(
  parameter int unsigned CLKS_PER_SEC = 10_000_000,
  parameter int unsigned PPS_TIMEOUT  = 15_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pps,
  input  logic        i_thunder_packet_dv,
  input  logic [7:0]  i_year_h,
  input  logic [7:0]  i_year_l,
  input  logic [7:0]  i_month,
  input  logic [7:0]  i_day,
  input  logic [7:0]  i_hour,
  input  logic [7:0]  i_minutes,
  input  logic [7:0]  i_seconds,
  output logic [15:0] o_year,
  output logic [7:0]  o_month,
  output logic [7:0]  o_day,
  output logic [7:0]  o_hour,
  output logic [7:0]  o_minutes,
  output logic [7:0]  o_seconds,
  output logic        o_time_valid,
  output logic        o_tick,
  output logic        o_sync_err,
  output logic        o_holdover
);

  tk_state_t state, state_nx;
  utc_time_t pkt, shadow, wk, o_time;
  logic [2:0]  pps_sync;
  logic        pps_evt, inj_evt, tick_evt, to_expire;
  logic        pps_pend, pkt_pend, loaded;
  logic [31:0] to_cnt;
  logic [4:0]  dim;
  logic        sec_wrap, min_wrap, hour_wrap, day_wrap, mon_wrap;

  assign pkt = {i_year_h, i_year_l, i_month, i_day, i_hour, i_minutes, i_seconds};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pps_sync <= '0;
      pps_evt  <= 1'b0;
    end else begin
      pps_sync <= {pps_sync[1:0], i_pps};
      pps_evt  <= pps_sync[1] & ~pps_sync[2];
    end
  end

`ifdef TOD_FLYWHEEL_EN
  logic holdover_q;

  // Outside holdover to_cnt measures PPS silence; inside it paces the flywheel seconds.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      to_cnt     <= '0;
      inj_evt    <= 1'b0;
      holdover_q <= 1'b0;
    end else begin
      inj_evt <= 1'b0;
      if (pps_evt) begin
        to_cnt     <= '0;
        holdover_q <= 1'b0;
      end else if (!holdover_q) begin
        if (to_cnt == PPS_TIMEOUT - 1) begin
          inj_evt    <= 1'b1;
          holdover_q <= 1'b1;
          to_cnt     <= '0;
        end else begin
          to_cnt <= to_cnt + 32'd1;
        end
      end else if (to_cnt == CLKS_PER_SEC - 1) begin
        inj_evt <= 1'b1;
        to_cnt  <= '0;
      end else begin
        to_cnt <= to_cnt + 32'd1;
      end
    end
  end

  assign o_holdover = holdover_q;
  assign to_expire  = 1'b0;
`else
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      to_cnt    <= '0;
      to_expire <= 1'b0;
    end else begin
      to_expire <= 1'b0;
      if (pps_evt) begin
        to_cnt <= '0;
      end else if (to_cnt != PPS_TIMEOUT) begin
        to_cnt    <= to_cnt + 32'd1;
        to_expire <= (to_cnt == PPS_TIMEOUT - 1);
      end
    end
  end

  assign inj_evt    = 1'b0;
  assign o_holdover = 1'b0;
`endif

  assign tick_evt = pps_evt | inj_evt;

  days_in_month u_dim (
    .month (wk.month),
    .leap  (wk.year[1:0] == 2'b00),
    .days  (dim)
  );

  assign sec_wrap  = wk.seconds >= SEC_MAX;
  assign min_wrap  = wk.minutes >= MIN_MAX;
  assign hour_wrap = wk.hour >= HOUR_MAX;
  assign day_wrap  = wk.day >= {3'b000, dim};
  assign mon_wrap  = wk.month >= MONTH_MAX;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (pkt_pend)      state_nx = ST_LOAD;
        else if (pps_pend) state_nx = ST_INC_SEC;
      end
      ST_LOAD:     state_nx = ST_IDLE;
      ST_INC_SEC:  state_nx = sec_wrap  ? ST_INC_MIN  : ST_DONE;
      ST_INC_MIN:  state_nx = min_wrap  ? ST_INC_HOUR : ST_DONE;
      ST_INC_HOUR: state_nx = hour_wrap ? ST_INC_DAY  : ST_DONE;
      ST_INC_DAY:  state_nx = day_wrap  ? ST_INC_MON  : ST_DONE;
      ST_INC_MON:  state_nx = mon_wrap  ? ST_INC_YEAR : ST_DONE;
      ST_INC_YEAR: state_nx = ST_DONE;
      ST_DONE:     state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pps_pend     <= 1'b0;
      pkt_pend     <= 1'b0;
      loaded       <= 1'b0;
      shadow       <= TIME_RESET;
      wk           <= TIME_RESET;
      o_time       <= TIME_RESET;
      o_time_valid <= 1'b0;
      o_tick       <= 1'b0;
      o_sync_err   <= 1'b0;
    end else begin
      o_tick     <= 1'b0;
      o_sync_err <= 1'b0;

      if ((state == ST_IDLE) && pkt_pend) pkt_pend <= 1'b0;
      if ((state == ST_IDLE) && !pkt_pend && pps_pend) pps_pend <= 1'b0;

      if (i_thunder_packet_dv) begin
        shadow     <= pkt;
        pkt_pend   <= 1'b1;
        o_sync_err <= o_time_valid && (pkt != o_time);
      end
      // An edge before any packet has nothing to advance and is dropped.
      if (tick_evt && (loaded || pkt_pend || i_thunder_packet_dv)) pps_pend <= 1'b1;

      if (to_expire) o_time_valid <= 1'b0;

      unique case (state)
        ST_LOAD: begin
          wk           <= shadow;
          o_time       <= shadow;
          o_time_valid <= 1'b1;
          loaded       <= 1'b1;
        end
        ST_INC_SEC:  wk.seconds <= sec_wrap  ? 8'd0 : wk.seconds + 8'd1;
        ST_INC_MIN:  wk.minutes <= min_wrap  ? 8'd0 : wk.minutes + 8'd1;
        ST_INC_HOUR: wk.hour    <= hour_wrap ? 8'd0 : wk.hour + 8'd1;
        ST_INC_DAY:  wk.day     <= day_wrap  ? 8'd1 : wk.day + 8'd1;
        ST_INC_MON:  wk.month   <= mon_wrap  ? 8'd1 : wk.month + 8'd1;
        ST_INC_YEAR: wk.year    <= wk.year + 16'd1;
        ST_DONE: begin
          o_time <= wk;
          o_tick <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_year    = o_time.year;
  assign o_month   = o_time.month;
  assign o_day     = o_time.day;
  assign o_hour    = o_time.hour;
  assign o_minutes = o_time.minutes;
  assign o_seconds = o_time.seconds;

endmodule

// File: tb/tb_utc_timekeeper.sv
// Directed + randomized bench for utc_timekeeper against a calendar-arithmetic model.
module tb_utc_timekeeper;

  localparam int unsigned CPS = 100;
  localparam int unsigned PTO = 400;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_pps = 1'b0;
  logic        i_thunder_packet_dv = 1'b0;
  logic [7:0]  i_year_h = '0, i_year_l = '0, i_month = '0, i_day = '0;
  logic [7:0]  i_hour = '0, i_minutes = '0, i_seconds = '0;
  logic [15:0] o_year;
  logic [7:0]  o_month, o_day, o_hour, o_minutes, o_seconds;
  logic        o_time_valid, o_tick, o_sync_err, o_holdover;

  utc_timekeeper #(.CLKS_PER_SEC(CPS), .PPS_TIMEOUT(PTO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pps(i_pps),
    .i_thunder_packet_dv(i_thunder_packet_dv),
    .i_year_h(i_year_h), .i_year_l(i_year_l), .i_month(i_month), .i_day(i_day),
    .i_hour(i_hour), .i_minutes(i_minutes), .i_seconds(i_seconds),
    .o_year(o_year), .o_month(o_month), .o_day(o_day), .o_hour(o_hour),
    .o_minutes(o_minutes), .o_seconds(o_seconds), .o_time_valid(o_time_valid),
    .o_tick(o_tick), .o_sync_err(o_sync_err), .o_holdover(o_holdover)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { int y; int mo; int d; int h; int mi; int s; } tm_t;

  int tests = 0;
  int fails = 0;

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dim_f(int y, int mo);
    case (mo)
      2:           return (y % 4 == 0) ? 29 : 28;
      4, 6, 9, 11: return 30;
      default:     return 31;
    endcase
  endfunction

  // Next second via seconds-of-day arithmetic; k = number of INC stages visited.
  function automatic tm_t next_sec(input tm_t t, output int k);
    tm_t n = t;
    int  sod;
    bit  dw = 0, mw = 0;
    sod = t.h * 3600 + t.mi * 60 + ((t.s > 59) ? 59 : t.s) + 1;
    if (sod == 86400) begin
      sod = 0;
      n.d = t.d + 1;
      if (n.d > dim_f(t.y, t.mo)) begin
        dw = 1; n.d = 1; n.mo = t.mo + 1;
        if (n.mo > 12) begin mw = 1; n.mo = 1; n.y = (t.y + 1) % 65536; end
      end
    end
    n.h = sod / 3600; n.mi = (sod / 60) % 60; n.s = sod % 60;
    k = 1 + int'(n.s == 0) + int'(n.s == 0 && n.mi == 0) + int'(sod == 0)
          + int'(dw) + int'(mw);
    return n;
  endfunction

  function automatic tm_t mk(int y, int mo, int d, int h, int mi, int s);
    tm_t t;
    t.y = y; t.mo = mo; t.d = d; t.h = h; t.mi = mi; t.s = s;
    return t;
  endfunction

  task automatic chk_time(input string tag, input tm_t e);
    chk({tag, ".year"}, 32'(o_year), e.y);
    chk({tag, ".month"}, 32'(o_month), e.mo);
    chk({tag, ".day"}, 32'(o_day), e.d);
    chk({tag, ".hour"}, 32'(o_hour), e.h);
    chk({tag, ".min"}, 32'(o_minutes), e.mi);
    chk({tag, ".sec"}, 32'(o_seconds), e.s);
  endtask

  task automatic drive_fields(input tm_t t);
    i_year_h = 8'(t.y >> 8); i_year_l = 8'(t.y);
    i_month = 8'(t.mo); i_day = 8'(t.d); i_hour = 8'(t.h);
    i_minutes = 8'(t.mi); i_seconds = 8'(t.s);
  endtask

  // err: sync_err the cycle after dv; err2: one cycle later. Outputs loaded on return.
  task automatic send_pkt(input tm_t t, output logic err, output logic err2);
    drive_fields(t);
    i_thunder_packet_dv = 1'b1;
    cyc();
    i_thunder_packet_dv = 1'b0;
    err = o_sync_err;
    cyc();
    err2 = o_sync_err;
    cyc();
  endtask

  task automatic pps_run(input int cycles, output int ticks, output int first);
    ticks = 0; first = -1;
    i_pps = 1'b1;
    for (int n = 1; n <= cycles; n++) begin
      cyc();
      if (n == 5) i_pps = 1'b0;
      if (o_tick) begin ticks++; if (first < 0) first = n; end
    end
    i_pps = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk_time(tag, mk(0, 1, 1, 0, 0, 0));
    chk({tag, ".valid"}, 32'(o_time_valid), 0);
    chk({tag, ".tick"}, 32'(o_tick), 0);
    chk({tag, ".sync_err"}, 32'(o_sync_err), 0);
    chk({tag, ".holdover"}, 32'(o_holdover), 0);
  endtask

  task automatic step_check(input string tag, input tm_t t);
    tm_t e;
    int  k, ticks, first;
    logic err, err2;
    e = next_sec(t, k);
    send_pkt(t, err, err2);
    chk_time({tag, ".load"}, t);
    chk({tag, ".valid"}, 32'(o_time_valid), 1);
    pps_run(20, ticks, first);
    chk({tag, ".ticks"}, ticks, 1);
    chk({tag, ".latency"}, first, 6 + k);
    chk_time({tag, ".next"}, e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tm_t  t, e;
    int   k, ticks, first, n;
    logic err, err2;

    repeat (3) cyc();
    chk_reset("reset");
    i_rst = 1'b0;
    cyc();

    pps_run(15, ticks, first);
    chk("preload.ticks", ticks, 0);
    chk("preload.valid", 32'(o_time_valid), 0);

    t = mk(2023, 12, 31, 23, 59, 59);
    drive_fields(t);
    i_thunder_packet_dv = 1'b1; cyc(); i_thunder_packet_dv = 1'b0;
    chk("first_load.sync_err", 32'(o_sync_err), 0);
    cyc(); cyc();
    pps_run(20, ticks, first);
    chk("year_roll.ticks", ticks, 1);
    chk("year_roll.latency", first, 12);
    chk_time("year_roll", mk(2024, 1, 1, 0, 0, 0));

    step_check("leap_feb", mk(2024, 2, 28, 23, 59, 59));
    chk_time("leap_feb.exp", mk(2024, 2, 29, 0, 0, 0));
    step_check("noleap_feb", mk(2023, 2, 28, 23, 59, 59));
    chk_time("noleap_feb.exp", mk(2023, 3, 1, 0, 0, 0));

    step_check("sync_base", mk(2024, 5, 10, 12, 0, 4));
    send_pkt(mk(2024, 5, 10, 12, 0, 7), err, err2);
    chk("sync.err", 32'(err), 1);
    chk("sync.err_width", 32'(err2), 0);
    chk("sync.sec", 32'(o_seconds), 7);
    send_pkt(mk(2024, 5, 10, 12, 0, 7), err, err2);
    chk("sync.match_err", 32'(err), 0);

    // Packet dv lands in the same cycle as the internal edge event.
    t = mk(2024, 6, 15, 10, 0, 0);
    send_pkt(t, err, err2);
    ticks = 0;
    i_pps = 1'b1;
    cyc(); cyc(); cyc();
    drive_fields(t);
    i_thunder_packet_dv = 1'b1;
    cyc();
    i_thunder_packet_dv = 1'b0;
    chk("same.sync_err", 32'(o_sync_err), 0);
    for (int i = 0; i < 20; i++) begin
      if (i == 2) i_pps = 1'b0;
      cyc();
      if (o_tick) ticks++;
    end
    chk("same.ticks", ticks, 1);
    chk_time("same", mk(2024, 6, 15, 10, 0, 1));

    for (int it = 0; it < 16; it++) begin
      t.y  = 1901 + int'($urandom_range(198));
      t.mo = 1 + int'($urandom_range(11));
      t.d  = ($urandom_range(1) == 1) ? dim_f(t.y, t.mo) : 1 + int'($urandom_range(dim_f(t.y, t.mo) - 1));
      t.h  = ($urandom_range(1) == 1) ? 23 : int'($urandom_range(23));
      t.mi = ($urandom_range(1) == 1) ? 59 : int'($urandom_range(59));
      t.s  = ($urandom_range(1) == 1) ? 59 : int'($urandom_range(59));
      if ($urandom_range(7) == 0) t.s = 60;
      step_check($sformatf("rand%0d", it), t);
    end

    // Reset while the cascade sits in INC_DAY.
    send_pkt(mk(2023, 12, 31, 23, 59, 59), err, err2);
    ticks = 0;
    i_pps = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (i == 5) i_pps = 1'b0;
      if (o_tick) ticks++;
    end
    i_rst = 1'b1;
    cyc();
    i_rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (o_tick) ticks++;
      cyc();
    end
    chk("rst_mid.ticks", ticks, 0);
    chk_reset("rst_mid");
    pps_run(15, ticks, first);
    chk("rst_mid.no_inc", ticks, 0);

    t = mk(2024, 7, 1, 8, 30, 10);
    step_check("pre_timeout", t);
`ifdef TOD_FLYWHEEL_EN
    n = 0;
    while (!o_tick && n < int'(PTO) + 50) begin cyc(); n++; end
    chk("fly.first_tick_seen", 32'(o_tick), 1);
    chk("fly.holdover", 32'(o_holdover), 1);
    chk("fly.valid", 32'(o_time_valid), 1);
    chk("fly.sec1", 32'(o_seconds), 12);
    cyc();
    n = 1;
    while (!o_tick && n < int'(CPS) + 20) begin cyc(); n++; end
    chk("fly.period", n, CPS);
    chk("fly.sec2", 32'(o_seconds), 13);
    pps_run(20, ticks, first);
    chk("fly.real_ticks", ticks, 1);
    chk("fly.holdover_clear", 32'(o_holdover), 0);
    chk("fly.sec3", 32'(o_seconds), 14);
`else
    ticks = 0;
    for (int i = 0; i < int'(PTO) - 40; i++) begin cyc(); if (o_tick) ticks++; end
    chk("timeout.valid_before", 32'(o_time_valid), 1);
    for (int i = 0; i < 60; i++) begin cyc(); if (o_tick) ticks++; end
    chk("timeout.valid_after", 32'(o_time_valid), 0);
    chk("timeout.no_ticks", ticks, 0);
    chk("timeout.holdover", 32'(o_holdover), 0);
    chk("timeout.sec_held", 32'(o_seconds), 11);
    send_pkt(mk(2024, 7, 1, 8, 31, 0), err, err2);
    chk("timeout.revalid", 32'(o_time_valid), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
